// File: rtl/hsk_tx_port_pkg.sv
// Shared constants for the byte-bus transmit port: handshake state codes
// and the default byte width.
package hsk_tx_port_pkg;

  localparam int BYTE_W = 8;

  // Handshake FSM state codes
  localparam logic [1:0] HSK_IDLE  = 2'b00;
  localparam logic [1:0] HSK_SETUP = 2'b01;
  localparam logic [1:0] HSK_REQ   = 2'b10;
  localparam logic [1:0] HSK_REL   = 2'b11;

  // Number of FIFO entries for a given pointer width
  function automatic int fifo_depth(input int depth_log2);
    return 1 << depth_log2;
  endfunction

endpackage

// File: rtl/hsk_tx_port_if.sv
// External byte bus: data plus 4-phase req/ack pair.
// master = transmitter (this port), slave = receiver.
interface hsk_tx_port_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] bus_out;
  logic             hsk_req;
  logic             hsk_ack;

  modport master (output bus_out, output hsk_req, input hsk_ack);
  modport slave  (input bus_out, input hsk_req, output hsk_ack);
endinterface

// File: rtl/hsk_tx_port_sync_fifo.sv
// Small synchronous FIFO: register array, wrapping rd/wr pointers, occupancy
// count, registered full/empty and a sticky overflow flag.
module hsk_tx_port_sync_fifo
  import hsk_tx_port_pkg::*;
#(
  parameter int WIDTH      = BYTE_W,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic             ovf
);

  localparam int DEPTH = fifo_depth(DEPTH_LOG2);
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   count, count_nxt;
  logic                  push, pop;

  assign push    = wr_en & ~full;
  assign pop     = rd_en & ~empty;
  assign rd_data = mem[rd_ptr];

  // Next occupancy; simultaneous push and pop leaves it unchanged
  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Storage array (no reset needed, contents qualified by count)
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Pointers, count and status flags; full/empty follow count_nxt so they
  // are valid the cycle after the push or pop
  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == FULL_CNT);
      empty <= (count_nxt == '0);
      if (wr_en & full) ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/hsk_tx_port.sv
// Transmit side of the byte-bus 4-phase handshake. Bytes from R_OUT are
// queued in a FIFO and sent one at a time over bus_out with req/ack.
module hsk_tx_port
  import hsk_tx_port_pkg::*;
#(
  parameter int WIDTH      = BYTE_W,
  parameter int DEPTH_LOG2 = 2,
  parameter int SYNC_STG   = 2
) (
  input  logic             g_clk,
  input  logic             g_clr,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] data_in,
  output logic             full,
  output logic             empty,
  output logic             ovf,
  output logic             busy,
  hsk_tx_port_if.master    tx
);

  logic [1:0]          state;
  logic [SYNC_STG-1:0] ack_sync;
  logic                ack_s;
  logic                pop;
  logic [WIDTH-1:0]    head;

  // Pop only on the IDLE->SETUP edge; head is latched into bus_out there
  assign pop  = (state == HSK_IDLE) & ~empty;
  assign busy = (state != HSK_IDLE);

  hsk_tx_port_sync_fifo #(
    .WIDTH      (WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk     (g_clk),
    .clr     (g_clr),
    .wr_en   (wr_en),
    .wr_data (data_in),
    .rd_en   (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .ovf     (ovf)
  );

  // Ack is asynchronous: shift it through SYNC_STG flops before use
  always_ff @(posedge g_clk) begin
    if (g_clr) ack_sync <= '0;
    else       ack_sync <= {ack_sync[SYNC_STG-2:0], tx.hsk_ack};
  end
  assign ack_s = ack_sync[SYNC_STG-1];

  // Handshake FSM; req is a registered output so it never glitches, and
  // bus_out only changes on the IDLE->SETUP edge so it is stable for the
  // whole req/ack cycle and holds the last byte while idle
  always_ff @(posedge g_clk) begin
    if (g_clr) begin
      state      <= HSK_IDLE;
      tx.bus_out <= '0;
      tx.hsk_req <= 1'b0;
    end else begin
      case (state)
        HSK_IDLE: begin
          if (!empty) begin
            tx.bus_out <= head;
            state      <= HSK_SETUP;
          end
        end
        HSK_SETUP: begin
          tx.hsk_req <= 1'b1;
          state      <= HSK_REQ;
        end
        HSK_REQ: begin
          // an ack already high on entry is taken as the ack
          if (ack_s) begin
            tx.hsk_req <= 1'b0;
            state      <= HSK_REL;
          end
        end
        default: begin
          if (!ack_s) state <= HSK_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hsk_tx_port.sv
// Bench for hsk_tx_port: a behavioural receiver records every byte it is
// offered; expected byte order comes from the queue of bytes pushed.
module tb_hsk_tx_port;

  localparam int W     = 8;
  localparam int DEPTH = 4;

  logic         g_clk = 1'b0;
  logic         g_clr = 1'b0;
  logic         wr_en = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         full, empty, ovf, busy;

  hsk_tx_port_if #(.WIDTH(W)) tx();

  hsk_tx_port #(.WIDTH(W), .DEPTH_LOG2(2), .SYNC_STG(2)) dut (
    .g_clk   (g_clk),
    .g_clr   (g_clr),
    .wr_en   (wr_en),
    .data_in (data_in),
    .full    (full),
    .empty   (empty),
    .ovf     (ovf),
    .busy    (busy),
    .tx      (tx)
  );

  always #5 g_clk = ~g_clk;

  int ncmp = 0;
  int nerr = 0;

  // receiver model state
  int           ack_dly = 1;
  bit           rx_hold = 1'b0;
  int           rx_cnt  = 0;
  bit           rx_seen = 1'b0;
  logic [W-1:0] rx_q[$];
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge g_clk); #1;
  endtask

  // Receiver: records the byte when req is first seen, acks after ack_dly
  // samples, drops ack ack_dly samples after req falls
  initial tx.hsk_ack = 1'b0;
  always begin
    @(posedge g_clk); #1;
    if (g_clr) begin
      tx.hsk_ack = 1'b0; rx_cnt = 0; rx_seen = 1'b0;
    end else if (!rx_hold) begin
      if (tx.hsk_req && !tx.hsk_ack) begin
        if (!rx_seen) begin rx_q.push_back(tx.bus_out); rx_seen = 1'b1; end
        rx_cnt++;
        if (rx_cnt >= ack_dly) begin
          check("bus_stable", tx.bus_out, rx_q[$]);
          tx.hsk_ack = 1'b1; rx_cnt = 0; rx_seen = 1'b0;
        end
      end else if (!tx.hsk_req && tx.hsk_ack) begin
        rx_cnt++;
        if (rx_cnt >= ack_dly) begin tx.hsk_ack = 1'b0; rx_cnt = 0; end
      end
    end
  end

  task automatic do_reset();
    g_clr = 1'b1; step(); step(); g_clr = 1'b0;
  endtask

  task automatic push(input logic [W-1:0] b);
    wr_en = 1'b1; data_in = b; step(); wr_en = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int lim);
    int n = 0;
    while (!(busy === 1'b0 && empty === 1'b1 && tx.hsk_ack === 1'b0) && n < lim) begin
      step(); n++;
    end
    check(tag, 32'(n < lim), 1);
  endtask

  task automatic wait_req(input string tag, input int lim);
    int n = 0;
    while (tx.hsk_req !== 1'b1 && n < lim) begin step(); n++; end
    check(tag, 32'(n < lim), 1);
  endtask

  // compare everything received since index base against exp_q
  task automatic check_order(input string tag, input int base);
    check({tag, "_cnt"}, rx_q.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size() && base + i < rx_q.size(); i++)
      check(tag, rx_q[base+i], exp_q[i]);
  endtask

  // stream bytes from exp_q, never letting more than DEPTH be outstanding
  task automatic stream(input string tag, input bit rnd_gap, input bit rnd_dly);
    int base = rx_q.size();
    int sent = 0;
    int n = 0;
    while (sent < exp_q.size() && n < 4000) begin
      if (rnd_dly) ack_dly = $urandom_range(1, 4);
      if ((sent - (rx_q.size() - base)) < DEPTH && (!rnd_gap || $urandom_range(0, 1) == 1)) begin
        push(exp_q[sent]); sent++;
      end else step();
      n++;
    end
    check({tag, "_push_to"}, 32'(sent == exp_q.size()), 1);
    wait_idle({tag, "_idle"}, 2000);
    check_order(tag, base);
    check({tag, "_ovf"}, ovf, 0);
  endtask

  initial begin
    int base;
    int n;

    // 1: reset
    do_reset();
    check("rst_req", tx.hsk_req, 0);
    check("rst_bus", tx.bus_out, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_ovf", ovf, 0);
    check("rst_busy", busy, 0);

    // 2: single byte, bus_out valid in SETUP before req rises
    ack_dly = 1;
    base = rx_q.size();
    push(8'hA5);
    n = 0;
    while (busy !== 1'b1 && n < 20) begin step(); n++; end
    check("t2_busy_to", 32'(n < 20), 1);
    check("t2_setup_req", tx.hsk_req, 0);
    check("t2_setup_bus", tx.bus_out, 8'hA5);
    wait_idle("t2_idle", 100);
    exp_q = {8'hA5};
    check_order("t2_rx", base);
    check("t2_empty", empty, 1);
    check("t2_bus_hold", tx.bus_out, 8'hA5);

    // 3: fill and overflow with receiver stalled
    rx_hold = 1'b1;
    base = rx_q.size();
    for (int i = 1; i <= 5; i++) push(8'(i));
    check("t3_full", full, 1);
    check("t3_ovf0", ovf, 0);
    push(8'h06);
    check("t3_ovf1", ovf, 1);
    check("t3_full2", full, 1);
    rx_hold = 1'b0;
    wait_idle("t3_idle", 500);
    exp_q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    check_order("t3_rx", base);
    check("t3_ovf_sticky", ovf, 1);
    do_reset();
    check("t3_ovf_clr", ovf, 0);

    // 4: push on the IDLE->SETUP edge while one entry is queued
    rx_hold = 1'b1;
    base = rx_q.size();
    push(8'h50);
    push(8'h51);
    wait_req("t4_req_to", 20);
    rx_hold = 1'b0;
    n = 0;
    while (busy !== 1'b0 && n < 100) begin step(); n++; end
    check("t4_idle_to", 32'(n < 100), 1);
    check("t4_pre_empty", empty, 0);
    push(8'h3C);
    check("t4_cnt1_empty", empty, 0);
    check("t4_cnt1_full", full, 0);
    step();
    check("t4_cnt1_empty2", empty, 0);
    wait_idle("t4_idle", 500);
    exp_q = {8'h50, 8'h51, 8'h3C};
    check_order("t4_rx", base);

    // 5: pointer wrap with slow receiver
    ack_dly = 5;
    exp_q.delete();
    for (int i = 0; i < 10; i++) exp_q.push_back(8'(i));
    stream("t5", 1'b0, 1'b0);

    // random bytes, gaps and receiver speed
    exp_q.delete();
    for (int i = 0; i < 24; i++) exp_q.push_back(8'($urandom));
    stream("rnd", 1'b1, 1'b1);

    // 6: reset while in REQ discards the in-flight byte
    ack_dly = 1;
    rx_hold = 1'b1;
    push(8'h77);
    wait_req("t6_req_to", 20);
    base = rx_q.size();
    g_clr = 1'b1; step(); g_clr = 1'b0;
    check("t6_req", tx.hsk_req, 0);
    check("t6_empty", empty, 1);
    check("t6_busy", busy, 0);
    rx_hold = 1'b0;
    repeat (30) step();
    check("t6_no_resend", rx_q.size(), base);
    check("t6_req_idle", tx.hsk_req, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
